// File: rtl/ct_spsram_pkg.sv
// ct_spsram_pkg: shared types and constants for the single-port SRAM wrapper.
//   - clear-engine FSM state encoding
//   - access-class constants and a decode helper (CEN/GWEN -> access class)
//   - default geometry used by the L2/ICache data and tag instantiations
package ct_spsram_pkg;

    localparam int unsigned CT_SPSRAM_DATA_WIDTH = 128;
    localparam int unsigned CT_SPSRAM_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } ct_spsram_state_e;

    localparam logic [1:0] ACC_NONE  = 2'd0;
    localparam logic [1:0] ACC_READ  = 2'd1;
    localparam logic [1:0] ACC_WRITE = 2'd2;

    // Both strobes are active low; chip enable dominates.
    function automatic logic [1:0] ct_spsram_acc(input logic cen, input logic gwen);
        logic [1:0] acc;
        if (cen) begin
            acc = ACC_NONE;
        end else if (gwen) begin
            acc = ACC_READ;
        end else begin
            acc = ACC_WRITE;
        end
        return acc;
    endfunction

endpackage

// File: rtl/ct_spsram_array.sv
// ct_spsram_array: behavioural DATA_WIDTH x 2**ADDR_WIDTH single-port array.
//   CLK, cpurst_b      clock, async active-low reset (read register only)
//   cen, gwen          chip enable / global write enable, active low
//   wen                per-bit write enable, active low
//   addr, din          access address and write data
//   dout               registered read data; holds until the next read
module ct_spsram_array
    import ct_spsram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CT_SPSRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = CT_SPSRAM_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic                  cen,
    input  logic                  gwen,
    input  logic [DATA_WIDTH-1:0] wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            acc;

    assign acc = ct_spsram_acc(cen, gwen);

    // Storage is never reset; bits with wen=1 keep their old value.
    always_ff @(posedge CLK) begin
        if (acc == ACC_WRITE) begin
            mem[addr] <= (mem[addr] & wen) | (din & ~wen);
        end
    end

    // Read register only loads on a read, giving the hold behaviour.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            dout <= '0;
        end else if (acc == ACC_READ) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ct_spsram_init_wrap.sv
// ct_spsram_init_wrap: parametrised single-port SRAM wrapper with clear engine.
//   CLK, cpurst_b      clock, async active-low reset
//   A, CEN, GWEN, WEN  address, chip enable, global write enable, per-bit write
//                      enable (all enables active low)
//   D, Q               write data, read data (held between reads)
//   init_req           one-cycle pulse requesting a full clear
//   init_busy          clear running; external accesses are dropped
//   init_done          at least one clear completed since reset
// Build option: SPSRAM_OREG_EN adds an output register (2-cycle read latency).
module ct_spsram_init_wrap
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = CT_SPSRAM_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH    = CT_SPSRAM_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA     = {DATA_WIDTH{1'b0}},
    parameter int unsigned           INIT_ON_RESET = 1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ct_spsram_state_e      state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  busy_nxt, done_nxt;

    logic                  clr_c;
    logic                  arr_cen, arr_gwen;
    logic [DATA_WIDTH-1:0] arr_wen, arr_din, arr_dout;
    logic [ADDR_WIDTH-1:0] arr_addr;

    // Clear engine state, counter and status flags.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_busy <= busy_nxt;
            init_done <= done_nxt;
        end
    end

    // Next state; IDLE is only ever reached from reset, so the auto-start
    // condition needs no separate "just released" flag.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = init_busy;
        done_nxt  = init_done;
        case (state)
            ST_IDLE: begin
                if ((INIT_ON_RESET != 0) || init_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (init_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // During a clear the counter owns the array with a full-mask write;
    // external strobes are ignored entirely.
    assign clr_c    = (state == ST_CLEAR);
    assign arr_cen  = clr_c ? 1'b0 : CEN;
    assign arr_gwen = clr_c ? 1'b0 : GWEN;
    assign arr_wen  = clr_c ? '0 : WEN;
    assign arr_addr = clr_c ? cnt : A;
    assign arr_din  = clr_c ? INIT_DATA : D;

    ct_spsram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .CLK      (CLK),
        .cpurst_b (cpurst_b),
        .cen      (arr_cen),
        .gwen     (arr_gwen),
        .wen      (arr_wen),
        .addr     (arr_addr),
        .din      (arr_din),
        .dout     (arr_dout)
    );

`ifdef SPSRAM_OREG_EN
    logic [DATA_WIDTH-1:0] q_oreg;

    // The read register already holds between reads, so a plain copy keeps
    // the hold behaviour one stage later.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            q_oreg <= '0;
        end else begin
            q_oreg <= arr_dout;
        end
    end

    assign Q = q_oreg;
`else
    assign Q = arr_dout;
`endif

endmodule

// File: tb/tb_ct_spsram_init_wrap.sv
// Testbench for ct_spsram_init_wrap: randomized and directed accesses checked
// by a scoreboard against a behavioural memory/clear model.
`timescale 1ns/1ps
module tb_ct_spsram_init_wrap;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [DW-1:0] INIT = 32'hA5A5_A5A5;
`ifdef SPSRAM_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          CLK = 1'b0;
    logic          cpurst_b = 1'b0;
    logic [AW-1:0] A = '0;
    logic          CEN = 1'b1;
    logic          GWEN = 1'b1;
    logic [DW-1:0] WEN = '1;
    logic [DW-1:0] D = '0;
    logic          init_req = 1'b0;
    logic          init_req2 = 1'b0;
    logic [DW-1:0] Q, Q2;
    logic          init_busy, init_done, init_busy2, init_done2;

    always #5 CLK = ~CLK;

    ct_spsram_init_wrap #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .INIT_DATA (INIT), .INIT_ON_RESET (1)
    ) u_dut (
        .CLK (CLK), .cpurst_b (cpurst_b), .A (A), .CEN (CEN), .GWEN (GWEN),
        .WEN (WEN), .D (D), .Q (Q), .init_req (init_req),
        .init_busy (init_busy), .init_done (init_done)
    );

    // Second instance without auto-clear, sharing the access bus.
    ct_spsram_init_wrap #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .INIT_DATA (INIT), .INIT_ON_RESET (0)
    ) u_dut_noinit (
        .CLK (CLK), .cpurst_b (cpurst_b), .A (A), .CEN (CEN), .GWEN (GWEN),
        .WEN (WEN), .D (D), .Q (Q2), .init_req (init_req2),
        .init_busy (init_busy2), .init_done (init_done2)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] val;
        bit            known;
    } exp_t;

    exp_t          sbq[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            edges    = 0;
    int            busy_cycles = 0;
    bit            mon_en   = 1'b0;
    logic [DW-1:0] exp_q    = '0;
    bit            exp_known = 1'b1;

    // Reference model: memory image plus "clear in progress" bookkeeping.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            m_busy, m_done, m_auto;
    int            m_idx;
    bit            m2_busy, m2_done;
    int            m2_idx;

    always @(posedge CLK) edges <= edges + 1;

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: adopt each expected read value when it becomes due, and compare
    // Q every cycle so hold behaviour is checked as well.
    always @(negedge CLK) begin
        if (mon_en) begin
            while (sbq.size() > 0 && sbq[0].due <= edges) begin
                exp_q     = sbq[0].val;
                exp_known = sbq[0].known;
                void'(sbq.pop_front());
            end
            if (exp_known) check("q", Q, exp_q);
        end
    end

    // Drive one cycle of stimulus, advance the model over the coming edge,
    // then check the status outputs shortly after that edge.
    task automatic step(input bit cen, input bit gwen, input logic [DW-1:0] wen,
                        input int a, input logic [DW-1:0] d,
                        input bit req, input bit req2);
        int e;
        CEN = cen; GWEN = gwen; WEN = wen; A = AW'(a); D = d;
        init_req = req; init_req2 = req2;
        e = edges + 1;
        if (m_busy) begin
            m_mem[m_idx]   = INIT;
            m_known[m_idx] = 1'b1;
            m_idx++;
            if (m_idx == DEPTH) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (!cen && gwen) begin
                sbq.push_back('{due: e + LAT - 1, val: m_mem[a], known: m_known[a]});
            end else if (!cen && !gwen) begin
                m_mem[a]   = (m_mem[a] & wen) | (d & ~wen);
                m_known[a] = m_known[a] || (wen == '0);
            end
            if (m_auto || req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
        m_auto = 1'b0;
        if (m2_busy) begin
            m2_idx++;
            if (m2_idx == DEPTH) begin
                m2_busy = 1'b0;
                m2_done = 1'b1;
            end
        end else if (req2) begin
            m2_busy = 1'b1;
            m2_idx  = 0;
        end
        @(posedge CLK);
        #1;
        init_req = 1'b0; init_req2 = 1'b0;
        if (init_busy) busy_cycles++;
        check("init_busy", DW'(init_busy), DW'(m_busy));
        check("init_done", DW'(init_done), DW'(m_done));
        check("init_busy_noinit", DW'(init_busy2), DW'(m2_busy));
        check("init_done_noinit", DW'(init_done2), DW'(m2_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, '1, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, '1, a, DW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
        step(1'b0, 1'b0, wen, a, d, 1'b0, 1'b0);
    endtask

    // Assert reset (asynchronously, between edges), check reset values,
    // then release and reinitialise the model.
    task automatic do_reset();
        mon_en = 1'b0;
        #2;
        cpurst_b = 1'b0;
        #1;
        check("rst_q", Q, '0);
        check("rst_busy", DW'(init_busy), '0);
        check("rst_done", DW'(init_done), '0);
        check("rst_done_noinit", DW'(init_done2), '0);
        repeat (2) @(posedge CLK);
        #1;
        cpurst_b = 1'b1;
        m_busy = 1'b0; m_done = 1'b0; m_auto = 1'b1; m_idx = 0;
        m2_busy = 1'b0; m2_done = 1'b0; m2_idx = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        sbq.delete();
        exp_q = '0; exp_known = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0; m_known[i] = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // Auto clear after reset: exactly DEPTH busy cycles, then all entries INIT.
        busy_cycles = 0;
        idle(DEPTH + 4);
        check("clear_busy_cycles", DW'(busy_cycles), DW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(LAT + 1);

        // Masked write over a zeroed entry, then back-to-back read.
        wr(3, '0, '0);
        wr(3, '1, 32'hFFFF_FF00);
        rd(3);
        idle(LAT + 1);
        check("mask_model", m_mem[3], 32'h0000_00FF);

        // Read hold through idle and write cycles.
        wr(5, 32'h1234_5678, '0);
        rd(5);
        idle(3);
        wr(5, 32'hDEAD_BEEF, '0);
        idle(2);
        rd(5);
        idle(LAT + 1);

        // init_req coincident with a write in DONE; writes and init_req
        // during the clear must be dropped / ignored.
        step(1'b0, 1'b0, '0, 7, 32'h0BAD_F00D, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 3, 32'h5555_0000 + i, i == 2, 1'b0);
        rd(9);
        idle(DEPTH);
        rd(3); rd(7); rd(9);
        idle(LAT + 1);

        // No-auto instance stayed idle; request a clear on it now.
        step(1'b1, 1'b1, '1, 0, '0, 1'b0, 1'b1);
        idle(DEPTH + 2);

        // Randomized traffic with occasional clear requests.
        for (int n = 0; n < 400; n++) begin
            logic [DW-1:0] w;
            w = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            step(1'($urandom_range(0, 3) == 0), 1'($urandom), w,
                 int'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 59) == 0));
        end
        idle(DEPTH + LAT + 2);

        // Reset in the middle of a clear, with the counter at 7.
        step(1'b1, 1'b1, '1, 0, '0, 1'b1, 1'b0);
        while (m_busy && m_idx < 7) idle(1);
        check("midclear_idx", DW'(m_idx), DW'(7));
        do_reset();
        idle(DEPTH + 3);
        for (int i = 0; i < DEPTH; i += 5) rd(i);
        idle(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_spsram_init_wrap.md
Name: ct_spsram_init_wrap

Overview:
- Parametrised single-port SRAM wrapper for L2/ICache data and tag arrays.
- Next generation of the fixed-size FPGA SRAM wrappers, with these additions:
  - configurable width and depth;
  - true per-bit write mask;
  - read-data hold;
  - a hardware clear engine that writes every entry with a known value after reset or on request.
- Sits between cache control logic and the behavioural array, which is an internal sub-module.

Parameters:
- DATA_WIDTH, 128, data/mask width in bits.
- ADDR_WIDTH, 12, address width; depth = 2**ADDR_WIDTH entries.
- INIT_DATA, {DATA_WIDTH{1'b0}}, value written by the clear engine.
- INIT_ON_RESET, 1, 1 = clear starts automatically after reset release.

Ports:
- CLK  input  1  clock.
- cpurst_b  input  1  asynchronous active-low reset.
- A  input  ADDR_WIDTH  access address.
- CEN  input  1  chip enable, active low.
- GWEN  input  1  global write enable, active low.
- WEN  input  DATA_WIDTH  per-bit write enable, active low.
- D  input  DATA_WIDTH  write data.
- Q  output  DATA_WIDTH  read data.
- init_req  input  1  single-cycle pulse requesting a full clear.
- init_busy  output  1  clear engine active; external accesses are ignored.
- init_done  output  1  at least one clear has completed since reset.

Behaviour:
- Interface: one clock CLK; reset cpurst_b is asynchronous, active-low. All flops reset asynchronously; array contents are not reset.
- Reset values: Q=0, init_busy=0, init_done=0, FSM=IDLE, clear counter=0.
- Access classes, evaluated each rising edge when init_busy=0:
  - CEN=1: no access.
  - CEN=0, GWEN=1: read.
  - CEN=0, GWEN=0: masked write.
- Masked write: array[A] bit i <= D[i] where WEN[i]=0; bits with WEN[i]=1 keep their value. All-ones WEN with GWEN=0 is a legal no-op write.
- Read latency: 1 cycle. Q shows array[A] on the edge after the read cycle. With SPSRAM_OREG_EN it is 2 cycles.
- Q hold: Q keeps the last read data through idle cycles, write cycles and the whole clear. Writes never update Q; there is no write-through.
- Read of an address written in the previous cycle returns the new merged data.
- Clear FSM:
  - IDLE -> CLEAR on the first cycle after reset release if INIT_ON_RESET=1, or on init_req=1.
  - CLEAR: counter drives the address. INIT_DATA is written with full mask, one entry per cycle, from 0 to 2**ADDR_WIDTH-1. init_busy=1.
  - CLEAR -> DONE in the cycle after the last entry is written; init_done <= 1 and init_busy <= 0 on that edge.
  - DONE -> CLEAR on init_req=1. Counter restarts at 0; init_done stays 1 during the re-clear.
  - A full clear takes exactly 2**ADDR_WIDTH cycles with init_busy=1.
- Boundary cases:
  - init_req during CLEAR is ignored and not queued.
  - External CEN=0 during CLEAR is dropped silently; nothing is written, Q is unchanged and no read is issued.
  - init_req coincident with an external access in IDLE/DONE: the access completes in that cycle and CLEAR begins next cycle.
  - Counter wraps to 0 only on the CLEAR exit.
  - Reset asserted mid-clear: FSM returns to IDLE, init_done=0, partially cleared contents are undefined. Clear restarts only per INIT_ON_RESET or init_req.

Optional Feature:
- Macro SPSRAM_OREG_EN.
- Defined: an extra output register stage after the array read register (2-cycle read latency). Both stages reset to 0. Q hold behaviour applies at the final stage, so Q changes only 2 cycles after a read.
- Undefined: the array read register drives Q directly (1-cycle read latency).
- The clear FSM is identical in both builds.

Decomposition:
- Shared package ct_spsram_pkg:
  - FSM state typedef: IDLE=2'b00, CLEAR=2'b01, DONE=2'b10.
  - Access-type constants.
  - Default width and depth constants used by cache instantiations.
- Sub-module ct_spsram_array:
  - Behavioural DATA_WIDTH x 2**ADDR_WIDTH array with per-bit masked write and a registered 1-cycle read.
  - Address mux, clear counter, FSM and output stage live in the top.

Test Plan:
- Reset release with INIT_ON_RESET=1, ADDR_WIDTH=4, INIT_DATA=0xA5..A5 -> init_busy=1 for exactly 16 cycles. Then init_done=1, and reads of all 16 entries return 0xA5..A5.
- Write D=all-ones, WEN=0xFFFF...FF00 to addr 3 after clear to 0, then read addr 3 -> Q=0x00..00FF after 1 cycle (2 with SPSRAM_OREG_EN).
- Read addr 5, then 3 idle cycles, then write addr 5 -> Q holds the addr-5 read data throughout the idle and write cycles.
- init_req in DONE plus a CEN=0 write issued mid-clear -> the write is dropped. Entry equals INIT_DATA after the clear; init_done stays 1.
- cpurst_b asserted at clear counter=7 -> Q=0, init_done=0, FSM IDLE. With INIT_ON_RESET=0 no clear occurs until init_req.
- Back-to-back write then read of the same address -> read returns the merged new data on the following cycle.
